// File: rtl/reg_dec_pkg.sv
// Shared types and constants for the sequenced register-enable decoder.
package reg_dec_pkg;

   localparam int unsigned IDX_W       = 5;
   localparam int unsigned NREG        = 32;
   localparam int unsigned HOLD_W      = 2;
   localparam int unsigned PULSE_W_MIN = 1;
   localparam int unsigned PULSE_W_MAX = 4;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   // True when a hold width fits the 2-bit hold counter.
   function automatic bit pulse_w_legal(input int unsigned pw);
      return (pw >= PULSE_W_MIN) && (pw <= PULSE_W_MAX);
   endfunction

   // Clamp an out-of-range hold width into the supported range.
   function automatic int unsigned pulse_w_clamp(input int unsigned pw);
      if (pulse_w_legal(pw)) return pw;
      if (pw < PULSE_W_MIN)  return PULSE_W_MIN;
      return PULSE_W_MAX;
   endfunction

endpackage

// File: rtl/decoder_5_to_32.sv
// Combinational 5-bit index to 32-bit one-hot decode with enable.
module decoder_5_to_32
   import reg_dec_pkg::*;
(
   input  logic [IDX_W-1:0] idx,
   input  logic             en,
   output logic [NREG-1:0]  onehot
);

   // Single set bit at the selected index, all zeros when disabled.
   always_comb begin
      onehot = '0;
      if (en) onehot[idx] = 1'b1;
   end

endmodule

// File: rtl/reg_enable_decoder.sv
// Sequenced 5-to-32 register-enable decoder.
// Accepts (index, count) over valid/ready and sweeps a registered one-hot
// enable across consecutive registers, PULSE_W cycles per register.
// Optional feature macro: R0_GUARD_EN (blocks register 0, adds guard_err).
module reg_enable_decoder
   import reg_dec_pkg::*;
#(
   parameter int unsigned PULSE_W = 1
)
(
   input  logic              clk,
   input  logic              clr,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [IDX_W-1:0]  req_idx,
   input  logic [IDX_W-1:0]  req_cnt,
   output logic [NREG-1:0]   en_out,
   output logic              busy,
`ifdef R0_GUARD_EN
   output logic              guard_err,
`endif
   output logic              last
);

   // Widths outside 1..4 are clamped so the hold counter never overflows.
   localparam int unsigned      PW_EFF      = pulse_w_clamp(PULSE_W);
   localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(PW_EFF - 1);

   state_t             state;
   state_t             state_nxt;
   logic [IDX_W-1:0]   cur_idx;
   logic [IDX_W-1:0]   idx_nxt;
   logic [IDX_W-1:0]   remain;
   logic [IDX_W-1:0]   remain_nxt;
   logic [HOLD_W-1:0]  hold;
   logic [HOLD_W-1:0]  hold_nxt;
   logic               slot_start;
   logic               dec_en;
   logic [NREG-1:0]    dec_out;

   // State register.
   always_ff @(posedge clk) begin
      if (clr) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state and slot-sequencing logic.
   always_comb begin
      state_nxt  = state;
      idx_nxt    = cur_idx;
      remain_nxt = remain;
      hold_nxt   = hold;
      slot_start = 1'b0;
      case (state)
         IDLE: begin
            if (req_valid && req_ready) begin
               state_nxt  = ACTIVE;
               idx_nxt    = req_idx;
               remain_nxt = req_cnt;
               hold_nxt   = HOLD_RELOAD;
               slot_start = 1'b1;
            end
         end
         ACTIVE: begin
            if (hold != '0) begin
               hold_nxt = hold - 1'b1;
            end else if (remain != '0) begin
               idx_nxt    = cur_idx + 1'b1;
               remain_nxt = remain - 1'b1;
               hold_nxt   = HOLD_RELOAD;
               slot_start = 1'b1;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Handshake and status outputs.
   always_comb begin
      req_ready = (state == IDLE) && !clr;
      busy      = (state == ACTIVE);
      last      = (state == ACTIVE) && (remain == '0);
   end

   // Sweep counters.
   always_ff @(posedge clk) begin
      if (clr) begin
         cur_idx <= '0;
         remain  <= '0;
         hold    <= '0;
      end else begin
         cur_idx <= idx_nxt;
         remain  <= remain_nxt;
         hold    <= hold_nxt;
      end
   end

   // The decode is fed from next-cycle values so the registered enable
   // lines up with the state it belongs to, with no extra latency.
`ifdef R0_GUARD_EN
   always_comb dec_en = (state_nxt == ACTIVE) && (idx_nxt != '0);
`else
   always_comb dec_en = (state_nxt == ACTIVE);
`endif

   decoder_5_to_32 u_dec (
      .idx    (idx_nxt),
      .en     (dec_en),
      .onehot (dec_out)
   );

   // Registered enable vector.
   always_ff @(posedge clk) begin
      if (clr) en_out <= '0;
      else     en_out <= dec_out;
   end

`ifdef R0_GUARD_EN
   // One-cycle pulse at the start of a blocked register-0 slot.
   always_ff @(posedge clk) begin
      if (clr) guard_err <= 1'b0;
      else     guard_err <= slot_start && (state_nxt == ACTIVE) && (idx_nxt == '0);
   end
`endif

endmodule

// File: tb/tb_reg_enable_decoder.sv
// Self-checking bench for reg_enable_decoder (instances with PULSE_W=1 and 3).
// Honours R0_GUARD_EN when defined.
module tb_reg_enable_decoder;

`ifdef R0_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic        clk;
   logic        clr;
   logic        req_valid [2];
   logic        req_ready [2];
   logic [4:0]  req_idx   [2];
   logic [4:0]  req_cnt   [2];
   logic [31:0] en_out    [2];
   logic        busy      [2];
   logic        last      [2];
   logic        guard_err [2];

   int n_checks = 0;
   int n_err    = 0;

   reg_enable_decoder #(.PULSE_W(1)) dut1 (
      .clk       (clk),
      .clr       (clr),
      .req_valid (req_valid[0]),
      .req_ready (req_ready[0]),
      .req_idx   (req_idx[0]),
      .req_cnt   (req_cnt[0]),
      .en_out    (en_out[0]),
      .busy      (busy[0]),
`ifdef R0_GUARD_EN
      .guard_err (guard_err[0]),
`endif
      .last      (last[0])
   );

   reg_enable_decoder #(.PULSE_W(3)) dut3 (
      .clk       (clk),
      .clr       (clr),
      .req_valid (req_valid[1]),
      .req_ready (req_ready[1]),
      .req_idx   (req_idx[1]),
      .req_cnt   (req_cnt[1]),
      .en_out    (en_out[1]),
      .busy      (busy[1]),
`ifdef R0_GUARD_EN
      .guard_err (guard_err[1]),
`endif
      .last      (last[1])
   );

`ifndef R0_GUARD_EN
   initial begin
      guard_err[0] = 1'b0;
      guard_err[1] = 1'b0;
   end
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: behaviour k cycles after acceptance.
   function automatic int pw_of(input int inst);
      return (inst == 0) ? 1 : 3;
   endfunction

   function automatic int reg_at(input int idx, input int pw, input int k);
      return (idx + k / pw) % 32;
   endfunction

   function automatic logic [31:0] exp_en(input int idx, input int pw, input int k);
      logic [31:0] one;
      int r;
      one = 32'h1;
      r = reg_at(idx, pw, k);
      if (GUARD && r == 0) return 32'h0;
      return one << r;
   endfunction

   function automatic logic exp_last(input int cnt, input int pw, input int k);
      return (k / pw) == cnt;
   endfunction

   function automatic logic exp_gerr(input int idx, input int pw, input int k);
      return GUARD && (reg_at(idx, pw, k) == 0) && (k % pw == 0);
   endfunction

   // Present a request, wait (bounded) for acceptance, return in first enable cycle.
   task automatic accept(input int inst, input int idx, input int cnt);
      int waited;
      waited = 0;
      @(negedge clk);
      req_valid[inst] = 1'b1;
      req_idx[inst]   = idx[4:0];
      req_cnt[inst]   = cnt[4:0];
      while (!req_ready[inst] && waited < 300) begin
         @(negedge clk);
         waited++;
      end
      n_checks++;
      if (req_ready[inst] !== 1'b1) begin
         n_err++;
         $display("FAIL accept_timeout inst=%0d ready=%b required 1", inst, req_ready[inst]);
      end
      @(posedge clk);
      @(negedge clk);
      req_valid[inst] = 1'b0;
   endtask

   task automatic test_reset();
      clr = 1'b1;
      req_valid[0] = 1'b1;
      req_idx[0]   = 5'd9;
      req_cnt[0]   = 5'd2;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if (en_out[i] !== 32'h0) begin n_err++; $display("FAIL reset_en inst=%0d got=%h exp=0", i, en_out[i]); end
         n_checks++;
         if (busy[i] !== 1'b0) begin n_err++; $display("FAIL reset_busy inst=%0d got=%b exp=0", i, busy[i]); end
         n_checks++;
         if (last[i] !== 1'b0) begin n_err++; $display("FAIL reset_last inst=%0d got=%b exp=0", i, last[i]); end
         n_checks++;
         if (guard_err[i] !== 1'b0) begin n_err++; $display("FAIL reset_gerr inst=%0d got=%b exp=0", i, guard_err[i]); end
         n_checks++;
         if (req_ready[i] !== 1'b0) begin n_err++; $display("FAIL reset_ready inst=%0d got=%b exp=0", i, req_ready[i]); end
      end
      req_valid[0] = 1'b0;
      clr = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if (req_ready[i] !== 1'b1) begin n_err++; $display("FAIL post_reset_ready inst=%0d got=%b exp=1", i, req_ready[i]); end
      end
      @(negedge clk);
      n_checks++;
      if (busy[0] !== 1'b0) begin n_err++; $display("FAIL clr_wins_busy got=%b exp=0", busy[0]); end
   endtask

   task automatic test_directed();
      int tbl_inst [3] = '{0, 0, 1};
      int tbl_idx  [3] = '{5, 30, 2};
      int tbl_cnt  [3] = '{0, 3, 1};
      for (int t = 0; t < 3; t++) begin
         int inst, pw, dur;
         inst = tbl_inst[t];
         pw   = pw_of(inst);
         dur  = (tbl_cnt[t] + 1) * pw;
         accept(inst, tbl_idx[t], tbl_cnt[t]);
         for (int k = 0; k < dur; k++) begin
            n_checks++;
            if (en_out[inst] !== exp_en(tbl_idx[t], pw, k)) begin
               n_err++; $display("FAIL dir_en t=%0d k=%0d got=%h exp=%h", t, k, en_out[inst], exp_en(tbl_idx[t], pw, k));
            end
            n_checks++;
            if (last[inst] !== exp_last(tbl_cnt[t], pw, k)) begin
               n_err++; $display("FAIL dir_last t=%0d k=%0d got=%b exp=%b", t, k, last[inst], exp_last(tbl_cnt[t], pw, k));
            end
            n_checks++;
            if (busy[inst] !== 1'b1 || req_ready[inst] !== 1'b0) begin
               n_err++; $display("FAIL dir_busy t=%0d k=%0d busy=%b ready=%b exp busy=1 ready=0", t, k, busy[inst], req_ready[inst]);
            end
            n_checks++;
            if (guard_err[inst] !== exp_gerr(tbl_idx[t], pw, k)) begin
               n_err++; $display("FAIL dir_gerr t=%0d k=%0d got=%b exp=%b", t, k, guard_err[inst], exp_gerr(tbl_idx[t], pw, k));
            end
            @(negedge clk);
         end
         n_checks++;
         if (en_out[inst] !== 32'h0 || busy[inst] !== 1'b0 || last[inst] !== 1'b0 || req_ready[inst] !== 1'b1) begin
            n_err++; $display("FAIL dir_end t=%0d en=%h busy=%b last=%b ready=%b exp 0/0/0/1", t, en_out[inst], busy[inst], last[inst], req_ready[inst]);
         end
      end
   endtask

   task automatic test_full_sweep();
      logic [31:0] seen;
      logic [31:0] want;
      int gerr_cnt;
      seen = 32'h0;
      gerr_cnt = 0;
      want = GUARD ? 32'hFFFF_FFFE : 32'hFFFF_FFFF;
      accept(0, 0, 31);
      for (int k = 0; k < 32; k++) begin
         n_checks++;
         if ($countones(en_out[0]) > 1 || (seen & en_out[0]) != 32'h0 || en_out[0] !== exp_en(0, 1, k)) begin
            n_err++; $display("FAIL full_onehot k=%0d got=%h exp=%h", k, en_out[0], exp_en(0, 1, k));
         end
         seen = seen | en_out[0];
         if (guard_err[0] === 1'b1) gerr_cnt++;
         @(negedge clk);
      end
      n_checks++;
      if (seen !== want) begin n_err++; $display("FAIL full_cover got=%h exp=%h", seen, want); end
      n_checks++;
      if (gerr_cnt != (GUARD ? 1 : 0)) begin n_err++; $display("FAIL full_gerr_count got=%0d exp=%0d", gerr_cnt, GUARD ? 1 : 0); end
      n_checks++;
      if (busy[0] !== 1'b0) begin n_err++; $display("FAIL full_end_busy got=%b exp=0", busy[0]); end
   endtask

   task automatic test_random();
      for (int it = 0; it < 24; it++) begin
         int inst, idx, cnt, pw, dur;
         inst = int'($urandom_range(0, 1));
         idx  = int'($urandom_range(0, 31));
         cnt  = (it % 6 == 5) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 6));
         pw   = pw_of(inst);
         dur  = (cnt + 1) * pw;
         accept(inst, idx, cnt);
         for (int k = 0; k < dur; k++) begin
            n_checks++;
            if (en_out[inst] !== exp_en(idx, pw, k) || last[inst] !== exp_last(cnt, pw, k) ||
                busy[inst] !== 1'b1 || guard_err[inst] !== exp_gerr(idx, pw, k)) begin
               n_err++;
               $display("FAIL rand it=%0d k=%0d en=%h exp=%h last=%b exp=%b busy=%b gerr=%b exp=%b",
                        it, k, en_out[inst], exp_en(idx, pw, k), last[inst], exp_last(cnt, pw, k),
                        busy[inst], guard_err[inst], exp_gerr(idx, pw, k));
            end
            @(negedge clk);
         end
         n_checks++;
         if (en_out[inst] !== 32'h0 || req_ready[inst] !== 1'b1) begin
            n_err++; $display("FAIL rand_end it=%0d en=%h ready=%b exp 0/1", it, en_out[inst], req_ready[inst]);
         end
      end
   endtask

   task automatic test_clr_mid_sweep();
      accept(0, 10, 5);
      n_checks++;
      if (en_out[0] !== 32'h0000_0400) begin n_err++; $display("FAIL clr_mid_first got=%h exp=00000400", en_out[0]); end
      @(negedge clk);
      n_checks++;
      if (en_out[0] !== 32'h0000_0800) begin n_err++; $display("FAIL clr_mid_second got=%h exp=00000800", en_out[0]); end
      clr = 1'b1;
      #1;
      n_checks++;
      if (req_ready[1] !== 1'b0) begin n_err++; $display("FAIL clr_ready_forced got=%b exp=0", req_ready[1]); end
      @(negedge clk);
      n_checks++;
      if (en_out[0] !== 32'h0 || busy[0] !== 1'b0 || last[0] !== 1'b0) begin
         n_err++; $display("FAIL clr_mid_abort en=%h busy=%b last=%b exp 0/0/0", en_out[0], busy[0], last[0]);
      end
      n_checks++;
      if (req_ready[0] !== 1'b0) begin n_err++; $display("FAIL clr_ready_held got=%b exp=0", req_ready[0]); end
      clr = 1'b0;
      #1;
      n_checks++;
      if (req_ready[0] !== 1'b1) begin n_err++; $display("FAIL clr_ready_return got=%b exp=1", req_ready[0]); end
      repeat (3) begin
         @(negedge clk);
         n_checks++;
         if (busy[0] !== 1'b0 || en_out[0] !== 32'h0) begin
            n_err++; $display("FAIL clr_no_resume busy=%b en=%h exp 0/0", busy[0], en_out[0]);
         end
      end
   endtask

   task automatic test_backpressure();
      int dur;
      dur = 3 * 3;
      accept(1, 7, 2);
      req_valid[1] = 1'b1;
      req_idx[1]   = 5'd20;
      req_cnt[1]   = 5'd0;
      for (int k = 0; k < dur; k++) begin
         n_checks++;
         if (en_out[1] !== exp_en(7, 3, k) || req_ready[1] !== 1'b0) begin
            n_err++; $display("FAIL bp_hold k=%0d en=%h exp=%h ready=%b exp=0", k, en_out[1], exp_en(7, 3, k), req_ready[1]);
         end
         @(negedge clk);
      end
      n_checks++;
      if (req_ready[1] !== 1'b1 || en_out[1] !== 32'h0) begin
         n_err++; $display("FAIL bp_ready ready=%b en=%h exp 1/0", req_ready[1], en_out[1]);
      end
      @(posedge clk);
      @(negedge clk);
      req_valid[1] = 1'b0;
      for (int k = 0; k < 3; k++) begin
         n_checks++;
         if (en_out[1] !== 32'h0010_0000 || last[1] !== 1'b1) begin
            n_err++; $display("FAIL bp_new k=%0d en=%h last=%b exp 00100000/1", k, en_out[1], last[1]);
         end
         @(negedge clk);
      end
      n_checks++;
      if (en_out[1] !== 32'h0 || busy[1] !== 1'b0) begin
         n_err++; $display("FAIL bp_end en=%h busy=%b exp 0/0", en_out[1], busy[1]);
      end
   endtask

   initial begin
      clr = 1'b1;
      for (int i = 0; i < 2; i++) begin
         req_valid[i] = 1'b0;
         req_idx[i]   = 5'd0;
         req_cnt[i]   = 5'd0;
      end
      test_reset();
      test_directed();
      test_full_sweep();
      test_clr_mid_sweep();
      test_backpressure();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired got=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
